// File: rtl/scheduler_pkg.sv
// Shared types for the sample scheduler: FSM state encoding, sample width,
// and a saturating counter helper.
package scheduler_pkg;

  localparam int SAMPLE_W = 16;
  localparam int OVR_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADC_START,
    ADC_ARM,
    ADC_WAIT,
    PROC,
    DAC_START,
    DAC_ARM,
    DAC_WAIT
  } sched_state_t;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Sample-rate timebase: tick_o high for the cycle where count == PERIOD-1.
// Combinational tick from the registered count; enable_i low holds count at 0.
module period_timer #(
  parameter int PERIOD = 50
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count <= '0;
    end else if (!enable_i || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick_o = enable_i && (count == LAST);

endmodule

// File: rtl/sample_scheduler.sv
// Sequences one sample period ADC -> PLL -> DAC with overrun and watchdog status.
// All outputs registered; adc_start_o one cycle after tick, dac_start_o two after result.
module sample_scheduler
  import scheduler_pkg::*;
#(
  parameter int PERIOD = 50,
  parameter int WDOG   = 255
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic                bypass_i,
  output logic                adc_start_o,
  input  logic                adc_idle_i,
  input  logic [SAMPLE_W-1:0] adc_data_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic [SAMPLE_W-1:0] result_i,
  input  logic                result_valid_i,
  output logic                dac_start_o,
  output logic [SAMPLE_W-1:0] dac_data_o,
  input  logic                dac_idle_i,
  output logic                overrun_o,
  output logic [OVR_W-1:0]    overrun_cnt_o,
  output logic                fault_o,
  output logic                busy_o
);

  localparam int              WD_W    = $clog2(WDOG + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

  sched_state_t    state, state_d;
  logic [WD_W-1:0] wdog;
  logic            tick;
  logic            abort;
  logic            capture;
  logic            result_take;

  period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  assign capture     = (state == ADC_WAIT) && adc_idle_i;
  assign result_take = (state == PROC) && result_valid_i;

  always_comb begin
    state_d = state;
    abort   = 1'b0;
    case (state)
      IDLE:      if (tick) state_d = ADC_START;
      ADC_START: state_d = ADC_ARM;
      ADC_ARM:   if (!adc_idle_i) state_d = ADC_WAIT;
      ADC_WAIT:  if (adc_idle_i) state_d = bypass_i ? DAC_START : PROC;
      PROC:      if (result_valid_i) state_d = DAC_START;
      DAC_START: state_d = DAC_ARM;
      DAC_ARM:   if (!dac_idle_i) state_d = DAC_WAIT;
      DAC_WAIT:  if (dac_idle_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A legitimate transition on the last allowed cycle wins over the abort.
    if (state != IDLE && state_d == state && wdog == WD_LAST) begin
      abort   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state          <= IDLE;
      wdog           <= '0;
      adc_start_o    <= 1'b0;
      dac_start_o    <= 1'b0;
      sample_valid_o <= 1'b0;
      sample_o       <= '0;
      dac_data_o     <= '0;
      overrun_o      <= 1'b0;
      overrun_cnt_o  <= '0;
      fault_o        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_d;
      wdog           <= (state_d != state || state_d == IDLE) ? '0 : wdog + WD_W'(1);
      busy_o         <= (state_d != IDLE);
      adc_start_o    <= (state == IDLE) && (state_d == ADC_START);
      // Delayed a cycle so dac_data_o is already stable when the writer starts.
      dac_start_o    <= (state == DAC_START);
      sample_valid_o <= capture;
      if (capture) sample_o <= adc_data_i;
      if (capture && bypass_i) begin
        dac_data_o <= adc_data_i;
      end else if (result_take) begin
        dac_data_o <= result_i;
      end
      if (tick && state != IDLE) begin
        overrun_o     <= 1'b1;
        overrun_cnt_o <= sat_inc(overrun_cnt_o);
      end
      if (abort) fault_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler with simple ADC, PLL and DAC response models.
module tb_sample_scheduler;

  localparam int ADC_BUSY = 20;
  localparam int DAC_BUSY = 20;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        bypass_i = 1'b0;
  logic        adc_start_o;
  logic        adc_idle_i = 1'b1;
  logic [15:0] adc_data_i = '0;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic [15:0] result_i = '0;
  logic        result_valid_i = 1'b0;
  logic        dac_start_o;
  logic [15:0] dac_data_o;
  logic        dac_idle_i = 1'b1;
  logic        overrun_o;
  logic [15:0] overrun_cnt_o;
  logic        fault_o;
  logic        busy_o;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rel;

  logic [15:0] adc_val = 16'h1234;
  logic        adc_stuck = 1'b0;
  logic        pll_en = 1'b1;
  int          pll_delay = 5;
  logic [15:0] pll_val = 16'h0F0F;

  int adc_q[$];
  int sv_q[$];
  int svd_q[$];
  int dac_q[$];
  int dacd_q[$];

  sample_scheduler #(.PERIOD(50), .WDOG(255)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .enable_i       (enable_i),
    .bypass_i       (bypass_i),
    .adc_start_o    (adc_start_o),
    .adc_idle_i     (adc_idle_i),
    .adc_data_i     (adc_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .dac_start_o    (dac_start_o),
    .dac_data_o     (dac_data_o),
    .dac_idle_i     (dac_idle_i),
    .overrun_o      (overrun_o),
    .overrun_cnt_o  (overrun_cnt_o),
    .fault_o        (fault_o),
    .busy_o         (busy_o)
  );

  initial forever #10 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk_i);
    if (adc_start_o) adc_q.push_back(cyc);
    if (sample_valid_o) begin
      sv_q.push_back(cyc);
      svd_q.push_back(int'(sample_o));
    end
    if (dac_start_o) begin
      dac_q.push_back(cyc);
      dacd_q.push_back(int'(dac_data_o));
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (adc_start_o && !adc_stuck) begin
      adc_idle_i = 1'b0;
      repeat (ADC_BUSY) @(negedge clk_i);
      adc_data_i = adc_val;
      adc_idle_i = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (sample_valid_o && pll_en) begin
      repeat (pll_delay) @(negedge clk_i);
      result_i       = pll_val;
      result_valid_i = 1'b1;
      @(negedge clk_i);
      result_valid_i = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (dac_start_o) begin
      dac_idle_i = 1'b0;
      repeat (DAC_BUSY) @(negedge clk_i);
      dac_idle_i = 1'b1;
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    adc_q.delete();
    sv_q.delete();
    svd_q.delete();
    dac_q.delete();
    dacd_q.delete();
  endtask

  // Long reset lets any in-flight model activity drain first.
  task automatic do_reset(input logic en);
    reset_ni = 1'b0;
    enable_i = en;
    step(70);
    reset_ni = 1'b1;
    rel = cyc;
    clear_logs();
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    step(5);
    total++; if (adc_start_o !== 1'b0) begin bad++; $display("FAIL rst_adc_start got=%0h want=0", adc_start_o); end
    total++; if (dac_start_o !== 1'b0) begin bad++; $display("FAIL rst_dac_start got=%0h want=0", dac_start_o); end
    total++; if (sample_valid_o !== 1'b0) begin bad++; $display("FAIL rst_sample_valid got=%0h want=0", sample_valid_o); end
    total++; if (sample_o !== 16'h0) begin bad++; $display("FAIL rst_sample got=%0h want=0", sample_o); end
    total++; if (dac_data_o !== 16'h0) begin bad++; $display("FAIL rst_dac_data got=%0h want=0", dac_data_o); end
    total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0h want=0", overrun_o); end
    total++; if (overrun_cnt_o !== 16'h0) begin bad++; $display("FAIL rst_overrun_cnt got=%0h want=0", overrun_cnt_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0h want=0", fault_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", busy_o); end
  endtask

  task automatic test_nominal();
    adc_stuck = 1'b0; bypass_i = 1'b0; pll_en = 1'b1; pll_delay = 5;
    adc_val = 16'h1234; pll_val = 16'h0F0F;
    do_reset(1'b1);
    step(190);
    total++; if (adc_q.size() !== 3) begin bad++; $display("FAIL nom_adc_count got=%0d want=3", adc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (qget(adc_q, i) !== rel + 50 + 50 * i) begin bad++; $display("FAIL nom_adc_start[%0d] got=%0d want=%0d", i, qget(adc_q, i), rel + 50 + 50 * i); end
      total++; if (qget(sv_q, i) !== rel + 71 + 50 * i) begin bad++; $display("FAIL nom_sample_valid[%0d] got=%0d want=%0d", i, qget(sv_q, i), rel + 71 + 50 * i); end
      total++; if (qget(svd_q, i) !== 'h1234) begin bad++; $display("FAIL nom_sample[%0d] got=%0h want=1234", i, qget(svd_q, i)); end
      total++; if (qget(dac_q, i) !== rel + 78 + 50 * i) begin bad++; $display("FAIL nom_dac_start[%0d] got=%0d want=%0d", i, qget(dac_q, i), rel + 78 + 50 * i); end
      total++; if (qget(dacd_q, i) !== 'h0F0F) begin bad++; $display("FAIL nom_dac_data[%0d] got=%0h want=f0f", i, qget(dacd_q, i)); end
    end
    total++; if (overrun_cnt_o !== 16'h0) begin bad++; $display("FAIL nom_overrun_cnt got=%0d want=0", overrun_cnt_o); end
    total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL nom_overrun got=%0h want=0", overrun_o); end
  endtask

  task automatic test_bypass();
    bypass_i = 1'b1; pll_en = 1'b0; adc_val = 16'h8001;
    do_reset(1'b1);
    step(90);
    total++; if (qget(adc_q, 0) !== rel + 50) begin bad++; $display("FAIL byp_adc_start got=%0d want=%0d", qget(adc_q, 0), rel + 50); end
    total++; if (qget(svd_q, 0) !== 'h8001) begin bad++; $display("FAIL byp_sample got=%0h want=8001", qget(svd_q, 0)); end
    total++; if (dac_q.size() !== 1) begin bad++; $display("FAIL byp_dac_count got=%0d want=1", dac_q.size()); end
    total++; if (qget(dac_q, 0) !== rel + 72) begin bad++; $display("FAIL byp_dac_start got=%0d want=%0d", qget(dac_q, 0), rel + 72); end
    total++; if (qget(dacd_q, 0) !== 'h8001) begin bad++; $display("FAIL byp_dac_data got=%0h want=8001", qget(dacd_q, 0)); end
    bypass_i = 1'b0; pll_en = 1'b1; adc_val = 16'h1234;
  endtask

  task automatic test_enable_gating();
    int k;
    do_reset(1'b0);
    step(200);
    total++; if (adc_q.size() !== 0) begin bad++; $display("FAIL en_no_adc got=%0d want=0", adc_q.size()); end
    total++; if (dac_q.size() !== 0) begin bad++; $display("FAIL en_no_dac got=%0d want=0", dac_q.size()); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL en_busy got=%0h want=0", busy_o); end
    enable_i = 1'b1;
    k = cyc;
    step(60);
    total++; if (adc_q.size() !== 1) begin bad++; $display("FAIL en_adc_count got=%0d want=1", adc_q.size()); end
    total++; if (qget(adc_q, 0) !== k + 50) begin bad++; $display("FAIL en_first_adc got=%0d want=%0d", qget(adc_q, 0), k + 50); end
  endtask

  task automatic test_overrun();
    pll_delay = 40;
    do_reset(1'b1);
    step(120);
    total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0h want=1", overrun_o); end
    total++; if (overrun_cnt_o !== 16'd1) begin bad++; $display("FAIL ovr_cnt1 got=%0d want=1", overrun_cnt_o); end
    step(120);
    total++; if (overrun_cnt_o !== 16'd2) begin bad++; $display("FAIL ovr_cnt2 got=%0d want=2", overrun_cnt_o); end
    total++; if (adc_q.size() !== 2) begin bad++; $display("FAIL ovr_adc_count got=%0d want=2", adc_q.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if (qget(adc_q, i) !== rel + 50 + 100 * i) begin bad++; $display("FAIL ovr_adc_start[%0d] got=%0d want=%0d", i, qget(adc_q, i), rel + 50 + 100 * i); end
      total++; if (qget(dac_q, i) !== rel + 113 + 100 * i) begin bad++; $display("FAIL ovr_dac_start[%0d] got=%0d want=%0d", i, qget(dac_q, i), rel + 113 + 100 * i); end
      total++; if (qget(dacd_q, i) !== 'h0F0F) begin bad++; $display("FAIL ovr_dac_data[%0d] got=%0h want=f0f", i, qget(dacd_q, i)); end
    end
    pll_delay = 5;
  endtask

  task automatic test_watchdog();
    adc_stuck = 1'b1;
    do_reset(1'b1);
    step(305);
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL wd_fault_early got=%0h want=0", fault_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wd_busy_before got=%0h want=1", busy_o); end
    step(1);
    total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL wd_fault got=%0h want=1", fault_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wd_idle got=%0h want=0", busy_o); end
    total++; if (overrun_cnt_o !== 16'd5) begin bad++; $display("FAIL wd_overrun_cnt got=%0d want=5", overrun_cnt_o); end
    total++; if (dac_q.size() !== 0) begin bad++; $display("FAIL wd_no_dac got=%0d want=0", dac_q.size()); end
    total++; if (adc_q.size() !== 1) begin bad++; $display("FAIL wd_adc_count got=%0d want=1", adc_q.size()); end
    adc_stuck = 1'b0;
  endtask

  task automatic test_reset_mid_proc();
    int rel2;
    pll_delay = 40;
    do_reset(1'b1);
    step(105);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0h want=1", busy_o); end
    total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL mid_overrun_pre got=%0h want=1", overrun_o); end
    total++; if (sample_o !== 16'h1234) begin bad++; $display("FAIL mid_sample_pre got=%0h want=1234", sample_o); end
    reset_ni = 1'b0;
    step(1);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy_rst got=%0h want=0", busy_o); end
    total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL mid_overrun_rst got=%0h want=0", overrun_o); end
    total++; if (overrun_cnt_o !== 16'h0) begin bad++; $display("FAIL mid_overrun_cnt_rst got=%0d want=0", overrun_cnt_o); end
    total++; if (sample_o !== 16'h0) begin bad++; $display("FAIL mid_sample_rst got=%0h want=0", sample_o); end
    total++; if (dac_data_o !== 16'h0) begin bad++; $display("FAIL mid_dac_data_rst got=%0h want=0", dac_data_o); end
    total++; if (adc_start_o !== 1'b0 || dac_start_o !== 1'b0 || sample_valid_o !== 1'b0 || fault_o !== 1'b0) begin
      bad++; $display("FAIL mid_pulses_rst got=%0b%0b%0b%0b want=0000", adc_start_o, dac_start_o, sample_valid_o, fault_o);
    end
    reset_ni = 1'b1;
    rel2 = cyc;
    clear_logs();
    step(60);
    total++; if (adc_q.size() !== 1) begin bad++; $display("FAIL mid_adc_count got=%0d want=1", adc_q.size()); end
    total++; if (qget(adc_q, 0) !== rel2 + 50) begin bad++; $display("FAIL mid_first_adc got=%0d want=%0d", qget(adc_q, 0), rel2 + 50); end
    total++; if (dac_q.size() !== 0) begin bad++; $display("FAIL mid_no_dac got=%0d want=0", dac_q.size()); end
    total++; if (overrun_cnt_o !== 16'h0) begin bad++; $display("FAIL mid_overrun_cnt got=%0d want=0", overrun_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bypass();
    test_enable_gating();
    test_overrun();
    test_watchdog();
    test_reset_mid_proc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
